mem_bist_ctrl: RTL
==================

// Module: mem_bist_ctrl
// PURPOSE
//  Built-in self-test controller for the dual-port RAM (separate write and read ports).
//  Runs a two-phase pattern test on start: write pattern, read back and compare; then repeat with the inverted pattern.
//  Reports pass/fail, error count and first failing address; sits between system control and the RAM ports.
// PARAMETERS
//  D_WIDTH  16  RAM data width
//  A_WIDTH  4   RAM address width; N = 2**A_WIDTH words, all tested
// PORTS
//  clk              in   1          rising-edge clock
//  rst_n            in   1          asynchronous, active-low reset
//  start            in   1          begin test; sampled only in IDLE
//  seed             in   D_WIDTH    pattern seed; captured when start is accepted
//  busy             out  1          high in WR/RD/DRAIN
//  done             out  1          one-cycle pulse when test completes
//  pass             out  1          1 = zero mismatches; valid from done, held until next start
//  err_count        out  A_WIDTH+2  number of mismatched reads, both phases (max 2N, never wraps)
//  first_err_addr   out  A_WIDTH    address of first mismatch; 0 if none
//  first_err_phase  out  1          phase of first mismatch; 0 if none
//  en_write         out  1          RAM write-port enable
//  write_enable     out  1          RAM write strobe
//  address_write    out  A_WIDTH    RAM write address
//  data_write       out  D_WIDTH    RAM write data
//  en_read          out  1          RAM read-port enable
//  address_read     out  A_WIDTH    RAM read address
//  data_read        in   D_WIDTH    RAM read data
// BEHAVIOUR
//  Reset (async, rst_n=0): FSM=IDLE, phase=0; every output 0, incl. pass, err_count, first_err_*.
//  All outputs are driven from registers; no combinational path from inputs to outputs.
//  Pattern P(a) = (seed_q + a) mod 2**D_WIDTH, with a zero-extended.
//  Phase 0 writes/expects P(a); phase 1 writes/expects ~P(a).
//  FSM: IDLE -start-> WR (clears err_count, first_err_*, pass; captures seed; phase=0).
//    WR: N cycles, cycle i drives en_write=write_enable=1, address_write=i, data_write=pattern(i).
//    RD: N cycles, cycle i drives en_read=1, address_read=i; write controls 0.
//    DRAIN: 1 cycle, RAM controls 0, final compare.
//    After DRAIN: if phase=0, go to WR with phase=1; otherwise go to DONE.
//    DONE: 1 cycle with done=1, pass=(err_count==0), then IDLE.
//  Read timing: the RAM samples address_read at the edge ending cycle i.
//    data_read is valid during cycle i+1 and is compared at the edge ending cycle i+1.
//    The last address is therefore compared in DRAIN.
//  On mismatch: err_count+1; the first mismatch since start latches first_err_addr/phase.
//  Total: busy high exactly 4N+2 cycles, done on cycle 4N+3 after start is accepted.
//  start outside IDLE is ignored, incl. the DONE cycle. start held high re-triggers on return to IDLE.
//  Address counter wraps N-1 -> 0 between states; pattern add wraps mod 2**D_WIDTH.
//  Reset mid-run: immediate return to reset values; RAM contents undefined; next start runs full test.
//  Results (pass, err_count, first_err_*) persist in IDLE until the next accepted start.
// TESTING
//  T1 reset: rst_n=0 with X inputs -> all outputs 0 asynchronously, before any clk edge.
//  T2 good RAM, seed=16'h1234, N=16:
//     writes 0..15 data 1234..1243, then EDCB..EDBC; busy 66 cycles; done pulse; pass=1; err_count=0.
//  T3 RAM model forces bit0 of word 5 to 0, seed=0:
//     err_count=1, first_err_addr=5, first_err_phase=0, pass=0.
//  T4 start held high 3 cycles, plus extra start pulse mid-RD:
//     exactly one test run (66 busy cycles); a second run starts only from IDLE.
//  T5 rst_n low during phase-1 RD for 1 cycle:
//     outputs 0 immediately, FSM IDLE; new start with good RAM -> pass=1, err_count=0.
//  T6 seed=16'hFFF8: P(7)=FFFF, P(8)=0000, P(15)=0007; phase-1 P(8) written as FFFF; pass=1.

Source files
------------

// File: rtl/mem_bist_ctrl.sv
// Two-phase pattern BIST controller for a dual-port RAM: writes P(a), reads back and compares,
// then repeats with ~P(a). Reports pass/fail, mismatch count and the first failing address/phase.
module mem_bist_ctrl #(
  parameter int unsigned D_WIDTH = 16,
  parameter int unsigned A_WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [D_WIDTH-1:0] seed,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [A_WIDTH+1:0] err_count,
  output logic [A_WIDTH-1:0] first_err_addr,
  output logic               first_err_phase,
  output logic               en_write,
  output logic               write_enable,
  output logic [A_WIDTH-1:0] address_write,
  output logic [D_WIDTH-1:0] data_write,
  output logic               en_read,
  output logic [A_WIDTH-1:0] address_read,
  input  logic [D_WIDTH-1:0] data_read
);

  localparam int unsigned C_WIDTH = A_WIDTH + 2;
  localparam logic [A_WIDTH-1:0] ADDR_LAST = {A_WIDTH{1'b1}};
  localparam logic [C_WIDTH-1:0] CNT_MAX   = {C_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_RD    = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [A_WIDTH-1:0]   addr_q, addr_d;
  logic                 phase_q, phase_d;
  logic [D_WIDTH-1:0]   seed_q, seed_d;
  logic                 cmp_valid_q, cmp_valid_d;
  logic [A_WIDTH-1:0]   cmp_addr_q, cmp_addr_d;
  logic [C_WIDTH-1:0]   err_count_q, err_count_d;
  logic [A_WIDTH-1:0]   first_err_addr_q, first_err_addr_d;
  logic                 first_err_phase_q, first_err_phase_d;
  logic                 pass_q, pass_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 en_write_q, en_write_d;
  logic                 write_enable_q, write_enable_d;
  logic [A_WIDTH-1:0]   address_write_q, address_write_d;
  logic [D_WIDTH-1:0]   data_write_q, data_write_d;
  logic                 en_read_q, en_read_d;
  logic [A_WIDTH-1:0]   address_read_q, address_read_d;

  // Test word for address a; phase 1 uses the bitwise inverse.
  function automatic logic [D_WIDTH-1:0] pattern(input logic [D_WIDTH-1:0] s,
                                                 input logic [A_WIDTH-1:0] a,
                                                 input logic               inv);
    logic [D_WIDTH-1:0] p;
    p = s + D_WIDTH'(a);
    return inv ? ~p : p;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= S_IDLE;
      addr_q            <= '0;
      phase_q           <= 1'b0;
      seed_q            <= '0;
      cmp_valid_q       <= 1'b0;
      cmp_addr_q        <= '0;
      err_count_q       <= '0;
      first_err_addr_q  <= '0;
      first_err_phase_q <= 1'b0;
      pass_q            <= 1'b0;
      done_q            <= 1'b0;
      busy_q            <= 1'b0;
      en_write_q        <= 1'b0;
      write_enable_q    <= 1'b0;
      address_write_q   <= '0;
      data_write_q      <= '0;
      en_read_q         <= 1'b0;
      address_read_q    <= '0;
    end else begin
      state_q           <= state_d;
      addr_q            <= addr_d;
      phase_q           <= phase_d;
      seed_q            <= seed_d;
      cmp_valid_q       <= cmp_valid_d;
      cmp_addr_q        <= cmp_addr_d;
      err_count_q       <= err_count_d;
      first_err_addr_q  <= first_err_addr_d;
      first_err_phase_q <= first_err_phase_d;
      pass_q            <= pass_d;
      done_q            <= done_d;
      busy_q            <= busy_d;
      en_write_q        <= en_write_d;
      write_enable_q    <= write_enable_d;
      address_write_q   <= address_write_d;
      data_write_q      <= data_write_d;
      en_read_q         <= en_read_d;
      address_read_q    <= address_read_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    addr_d            = addr_q;
    phase_d           = phase_q;
    seed_d            = seed_q;
    cmp_valid_d       = 1'b0;
    cmp_addr_d        = cmp_addr_q;
    err_count_d       = err_count_q;
    first_err_addr_d  = first_err_addr_q;
    first_err_phase_d = first_err_phase_q;
    pass_d            = pass_q;
    done_d            = 1'b0;

    // Read data returns one cycle after its address; compare against the word requested then.
    if (cmp_valid_q && (data_read != pattern(seed_q, cmp_addr_q, phase_q))) begin
      if (err_count_q == '0) begin
        first_err_addr_d  = cmp_addr_q;
        first_err_phase_d = phase_q;
      end
      if (err_count_q != CNT_MAX) begin
        err_count_d = err_count_q + C_WIDTH'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d           = S_WR;
          addr_d            = '0;
          phase_d           = 1'b0;
          seed_d            = seed;
          err_count_d       = '0;
          first_err_addr_d  = '0;
          first_err_phase_d = 1'b0;
          pass_d            = 1'b0;
        end
      end
      S_WR: begin
        addr_d = addr_q + A_WIDTH'(1);
        if (addr_q == ADDR_LAST) begin
          state_d = S_RD;
        end
      end
      S_RD: begin
        cmp_valid_d = 1'b1;
        cmp_addr_d  = addr_q;
        addr_d      = addr_q + A_WIDTH'(1);
        if (addr_q == ADDR_LAST) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        addr_d = '0;
        if (!phase_q) begin
          state_d = S_WR;
          phase_d = 1'b1;
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = (err_count_d == '0);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // RAM port controls are decoded from the next state so they leave straight from flops.
    busy_d          = (state_d == S_WR) || (state_d == S_RD) || (state_d == S_DRAIN);
    en_write_d      = (state_d == S_WR);
    write_enable_d  = en_write_d;
    address_write_d = en_write_d ? addr_d : '0;
    data_write_d    = en_write_d ? pattern(seed_d, addr_d, phase_d) : '0;
    en_read_d       = (state_d == S_RD);
    address_read_d  = en_read_d ? addr_d : '0;
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_count_q;
  assign first_err_addr  = first_err_addr_q;
  assign first_err_phase = first_err_phase_q;
  assign en_write        = en_write_q;
  assign write_enable    = write_enable_q;
  assign address_write   = address_write_q;
  assign data_write      = data_write_q;
  assign en_read         = en_read_q;
  assign address_read    = address_read_q;

endmodule
